// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU pipeline control blocks.
package cpu_ctrl_pkg;

  localparam int unsigned CNT_W = 32;
  localparam logic [4:0]  XZR   = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter32.sv
// Saturating event counter used for the pipeline performance counters.
module sat_counter32
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, taken-branch flushes and data-memory
// freezes, with stall/flush counters and a sticky memory timeout.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic        DELAY_SLOT  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_br_taken,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic             exmem_mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwr_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam int unsigned WAIT_W = 8;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              w_memwait;
  logic              w_loaduse;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_memwait = exmem_mem_req & ~mem_ready & (r_state != ERR);

  // A load whose result the ID instruction needs before MEM can forward it.
  assign w_loaduse = idex_mem_read & idex_reg_write & (idex_rd != XZR) &
                     ((id_uses_rn & (id_rn == idex_rd)) |
                      (id_uses_rm & (id_rm == idex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    memwr_bubble   = 1'b0;

    // The wait counter holds the number of waiting cycles including this one.
    unique case (r_state)
      RUN: begin
        if (w_memwait) begin
          w_wait_cnt_nxt = WAIT_W'(1);
          w_state_nxt    = (MEM_TIMEOUT <= 1) ? ERR : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!w_memwait) begin
          w_state_nxt = RUN;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          if (32'(w_wait_cnt_nxt) >= MEM_TIMEOUT) begin
            w_state_nxt = ERR;
          end
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    if (!reset) begin
      if ((r_state == ERR) || w_memwait) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwr_bubble = 1'b1;
      end else if (w_loaduse) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (!DELAY_SLOT && id_br_taken) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign mem_err     = (r_state == ERR);
  assign w_stall_inc = ~pc_en;
  assign w_flush_inc = ifid_flush;

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule
